// File: rtl/wrapper_seq_ctrl.sv
// Sequencing wrapper: feeds up to N latched operands to a single-element
// engine over a start/done handshake and collects the results.
module wrapper_seq_ctrl #(
  parameter int N  = 4,
  parameter int XW = 8,
  parameter int RW = 16,
  parameter int TO = 255,
  localparam int CW = $clog2(N + 1),
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wStart,
  input  logic [CW-1:0]   nElem,
  input  logic [N*XW-1:0] xIn,
  input  logic [XW-1:0]   uIn,
  input  logic            engDone,
  input  logic [RW-1:0]   engResult,
  output logic            engStart,
  output logic [XW-1:0]   engX,
  output logic [XW-1:0]   engU,
  output logic [IW-1:0]   idx,
  output logic            wr,
  output logic [N*RW-1:0] resOut,
  output logic            busy,
  output logic            wDone,
  output logic            err
);

  localparam int TW = (TO > 1) ? $clog2(TO + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    STORE
  } state_t;

  state_t            state;
  logic [N*XW-1:0]   xreg;
  logic [IW-1:0]     last;
  logic [TW-1:0]     tcnt;
  logic [CW-1:0]     n_eff;

  // Zero or out-of-range counts mean a full job.
  always_comb begin
    n_eff = nElem;
    if (nElem == '0 || nElem > CW'(N))
      n_eff = CW'(N);
  end

  assign engStart = (state == START);
  assign wr       = (state == STORE);
  assign busy     = (state != IDLE);
  assign wDone    = (state == IDLE);
  assign engX     = xreg[XW-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      xreg   <= '0;
      engU   <= '0;
      last   <= '0;
      idx    <= '0;
      tcnt   <= '0;
      resOut <= '0;
      err    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (wStart) begin
            xreg   <= xIn;
            engU   <= uIn;
            last   <= IW'(n_eff - CW'(1));
            resOut <= '0;
            idx    <= '0;
            tcnt   <= '0;
            err    <= 1'b0;
            state  <= LOAD;
          end
        end
        LOAD: begin
          if (!wStart)
            state <= START;
        end
        START: begin
          tcnt  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (engDone) begin
            resOut[idx*RW +: RW] <= engResult;
            state <= STORE;
          end else if (tcnt == TW'(TO - 1)) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        STORE: begin
          if (idx == last) begin
            state <= IDLE;
          end else begin
            xreg  <= xreg >> XW;
            idx   <= idx + 1'b1;
            state <= START;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wrapper_seq_ctrl.sv
// Directed bench for wrapper_seq_ctrl with a scripted engine responder.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_wrapper_seq_ctrl;

  localparam int N  = 4;
  localparam int XW = 8;
  localparam int RW = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          wStart;
  logic [2:0]    nElem;
  logic [31:0]   xIn;
  logic [7:0]    uIn;
  logic          engDone;
  logic [15:0]   engResult;
  logic          engStart;
  logic [7:0]    engX;
  logic [7:0]    engU;
  logic [1:0]    idx;
  logic          wr;
  logic [63:0]   resOut;
  logic          busy;
  logic          wDone;
  logic          err;

  int errors = 0;
  int checks = 0;
  int starts;
  int wrs;
  int cyc;
  logic [7:0] ex [4];

  wrapper_seq_ctrl #(.N(N), .XW(XW), .RW(RW), .TO(TO)) dut (
    .clk(clk), .rst(rst), .wStart(wStart), .nElem(nElem),
    .xIn(xIn), .uIn(uIn), .engDone(engDone),
    .engResult(engResult), .engStart(engStart), .engX(engX),
    .engU(engU), .idx(idx), .wr(wr), .resOut(resOut),
    .busy(busy), .wDone(wDone), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // k: WAIT cycle (from 0) where engDone is raised; mute: element that
  // never gets a response; relem: element whose WAIT gets a reset.
  task automatic job(input logic [2:0] ne, input logic [31:0] x,
                     input logic [7:0] u, input int k, input int mute,
                     input int hold, input int relem);
    int wj;
    @(negedge clk);
    wStart = 1'b1;
    nElem  = ne;
    xIn    = x;
    uIn    = u;
    starts = 0;
    wrs    = 0;
    cyc    = 0;
    wj     = -1;
    for (int i = 0; i < 4; i++) ex[i] = 8'h00;
    @(negedge clk);
    chk("load_busy", 64'(busy), 64'd1);
    chk("load_err_clr", 64'(err), 64'd0);
    for (int i = 1; i < hold; i++) begin
      xIn = ~x;
      @(negedge clk);
      chk("hold_nostart", 64'(engStart), 64'd0);
    end
    wStart = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (wDone) break;
      cyc++;
      engDone = 1'b0;
      if (cyc == 1) chk("first_start", 64'(engStart), 64'd1);
      if (wr) begin
        wrs++;
        wj = -1;
      end else if (engStart) begin
        chk("start_idx", 64'(idx), 64'(starts));
        if (starts < 4) ex[starts] = engX;
        starts++;
        wj = 0;
      end else if (wj >= 0) begin
        if (starts - 1 == relem && wj == 1) begin
          rst = 1'b0;
          #1;
          chk("arst_wdone", 64'(wDone), 64'd1);
          chk("arst_res", resOut, 64'd0);
          chk("arst_start", 64'(engStart), 64'd0);
          chk("arst_busy", 64'(busy), 64'd0);
          chk("arst_idx", 64'(idx), 64'd0);
          chk("arst_wrs", 64'(wrs), 64'd2);
          @(negedge clk);
          chk("arst_nowr", 64'(wr), 64'd0);
          rst = 1'b1;
          return;
        end
        if (wj == k && starts - 1 != mute) begin
          engDone   = 1'b1;
          engResult = 16'(ex[starts-1]) * 16'(u);
        end
        wj++;
      end
    end
    engDone = 1'b0;
    chk("job_end", 64'(wDone), 64'd1);
  endtask

  task automatic chk_full(input string tag);
    chk({tag, "_starts"}, 64'(starts), 64'd4);
    chk({tag, "_x0"}, 64'(ex[0]), 64'h01);
    chk({tag, "_x1"}, 64'(ex[1]), 64'h02);
    chk({tag, "_x2"}, 64'(ex[2]), 64'h03);
    chk({tag, "_x3"}, 64'(ex[3]), 64'h04);
    chk({tag, "_res"}, resOut, 64'h0014_000F_000A_0005);
    chk({tag, "_wrs"}, 64'(wrs), 64'd4);
    chk({tag, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    rst       = 1'b0;
    wStart    = 1'b0;
    nElem     = 3'd0;
    xIn       = 32'h0;
    uIn       = 8'h0;
    engDone   = 1'b0;
    engResult = 16'h0;
    #2;
    chk("rst_start", 64'(engStart), 64'd0);
    chk("rst_wr", 64'(wr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_res", resOut, 64'd0);
    chk("rst_engx", 64'(engX), 64'd0);
    chk("rst_engu", 64'(engU), 64'd0);
    chk("rst_idx", 64'(idx), 64'd0);
    chk("rst_wdone", 64'(wDone), 64'd1);
    @(negedge clk);
    rst = 1'b1;

    job(3'd4, 32'h04030201, 8'h05, 2, -1, 1, -1);
    chk_full("n4");
    chk("n4_cyc", 64'(cyc), 64'd20);
    chk("n4_engu", 64'(engU), 64'h05);

    job(3'd2, 32'h04030201, 8'h05, 2, -1, 1, -1);
    chk("n2_starts", 64'(starts), 64'd2);
    chk("n2_wrs", 64'(wrs), 64'd2);
    chk("n2_res", resOut, 64'h0000_0000_000A_0005);
    chk("n2_cyc", 64'(cyc), 64'd10);

    job(3'd0, 32'h04030201, 8'h05, 2, -1, 1, -1);
    chk_full("n0");

    job(3'd7, 32'h04030201, 8'h05, 2, -1, 1, -1);
    chk_full("n7");

    job(3'd4, 32'h04030201, 8'h05, 0, -1, 1, -1);
    chk_full("k0");
    chk("k0_cyc", 64'(cyc), 64'd12);

    job(3'd4, 32'h04030201, 8'h05, 2, 1, 1, -1);
    chk("to_err", 64'(err), 64'd1);
    chk("to_res", resOut, 64'h0000_0000_0000_0005);
    chk("to_wrs", 64'(wrs), 64'd1);
    chk("to_starts", 64'(starts), 64'd2);
    chk("to_cyc", 64'(cyc), 64'd14);

    job(3'd4, 32'h04030201, 8'h05, 2, -1, 5, -1);
    chk_full("hold");

    job(3'd4, 32'h04030201, 8'h05, 2, -1, 1, 2);
    job(3'd4, 32'h04030201, 8'h05, 2, -1, 1, -1);
    chk_full("post_rst");

    job(3'd1, 32'h04030201, 8'h05, TO - 1, -1, 1, -1);
    chk("edge_res", resOut, 64'h0000_0000_0000_0005);
    chk("edge_err", 64'(err), 64'd0);
    chk("edge_wrs", 64'(wrs), 64'd1);
    chk("edge_cyc", 64'(cyc), 64'd10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wrapper_seq_ctrl.md
# wrapper_seq_ctrl

Parametrised wrapper around a single-element accelerator engine. It latches a packed vector of up to N operands plus a shared second operand and feeds the elements to the engine one at a time through an engStart/engDone handshake. It collects each engine result into an indexed result vector and signals completion on wDone. It adds a runtime element count, a WAIT-state timeout with an error flag, and an element index output to the older fixed wrapper controller.

## Interface

Parameters:
- N, 4, maximum number of elements per job (≥1)
- XW, 8, element / shared-operand width
- RW, 16, engine result width
- TO, 255, engine timeout in cycles spent in WAIT (≥1)

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- wStart  in  1  job request, level
- nElem  in  clog2(N+1)  elements to process; 0 or >N means N
- xIn  in  N*XW  packed operands, element 0 in bits [XW-1:0]
- uIn  in  XW  shared operand
- engDone  in  1  engine result valid
- engResult  in  RW  engine result, sampled when engDone=1 in WAIT
- engStart  out  1  one-cycle engine start pulse
- engX  out  XW  current element to engine
- engU  out  XW  latched shared operand to engine
- idx  out  clog2(N)  index of the current element (max(1,clog2(N)) bits)
- wr  out  1  one-cycle pulse per stored result
- resOut  out  N*RW  results, element i in [i*RW +: RW]
- busy  out  1  job in progress
- wDone  out  1  idle / job complete
- err  out  1  last job aborted by timeout

## Operation

States: IDLE, LOAD, START, WAIT, STORE.
- IDLE: wDone=1, busy=0. If wStart=1, the same edge does all of the following, then goes to LOAD:
  - latch xIn into the X shift register and uIn into engU
  - latch effective count cnt, from nElem
  - clear resOut, idx, err and the timeout counter
- LOAD: busy=1. Stays while wStart=1; goes to START on wStart=0. This is the release handshake.
- START: engStart=1 for exactly one cycle; the timeout counter is cleared; goes to WAIT.
- WAIT: engStart=0. The timeout counter increments each cycle.
  - engDone=1: write engResult into resOut[idx*RW +: RW] on that edge; go to STORE.
  - Otherwise, if the counter reaches TO-1: set err=1 and go to IDLE. resOut keeps the results already written.
  - engDone and timeout in the same cycle: engDone wins.
- STORE: wr=1.
  - If idx==cnt-1: go to IDLE (job done).
  - Else: shift the X register right by XW, increment idx, go to START.
- engX is always X register bits [XW-1:0].
- engU is held constant through the job.
- engDone outside WAIT is ignored.
- wStart outside IDLE/LOAD is ignored. A new job needs wStart high in IDLE.
- err is sticky until the next job is accepted.

## Timing

- Reset (rst=0, asynchronous): state IDLE. All of the following clear immediately:
  - engStart=0, wr=0, busy=0, err=0
  - resOut=0, engX=0, engU=0, idx=0
  - wDone=1
- Reset mid-job aborts with no wr pulse. Outputs resume on the first clk edge after rst=1.
- Control outputs are decoded combinationally from state. Data outputs are registered.
- Per element: START (1 cycle) + WAIT (k+1 cycles if engDone arrives in the k-th WAIT cycle, k from 0) + STORE (1 cycle).
- The first engStart comes 1 cycle after wStart falls in LOAD.
- A job of c elements with zero-wait engine takes c×3 cycles from START to the return to IDLE.
- wDone rises the cycle after the final STORE. resOut is final by then.
- Timeout: with no engDone, err rises and the state returns to IDLE TO cycles after WAIT entry.

## Test plan

- N=4, XW=8, nElem=4, xIn=0x04030201, uIn=0x05; engine returns x*u after 2 WAIT cycles.
  - Required: 4 engStart pulses, engX = 1,2,3,4 in order.
  - Required: resOut = 0x0014_000F_000A_0005, 4 wr pulses, wDone=1, err=0.
- nElem=2, same xIn: exactly 2 engStart and 2 wr pulses; resOut[63:32]=0; wDone returns after the second STORE.
- nElem=0 and, separately, nElem=7: each processes 4 elements, identical to the first scenario.
- TO=8, engDone never asserted for element 1:
  - Required: err=1 after 8 WAIT cycles; state returns to IDLE.
  - Required: resOut holds only element 0's result; exactly 1 wr pulse.
  - Required: the next job clears err.
- wStart held high 5 cycles: no engStart until the cycle after the fall. Changing xIn during LOAD does not alter engX.
- rst pulled low in WAIT of element 2:
  - Required: asynchronous return to wDone=1, resOut=0, engStart=0.
  - Required: after release, a fresh job completes correctly.
- engDone asserted in the same cycle the timeout expires: result stored, err stays 0.
